// File: rtl/scope_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : scope_decimator_if
// Description : Valid/ready sample stream. The master drives dat/vld, the
//               slave drives rdy.
// Revision    : 1.0 - initial release
// ============================================================================
interface scope_decimator_if #(
    parameter int W = 14
) ();
    logic [W-1:0] dat;
    logic         vld;
    logic         rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface
`default_nettype wire

// File: rtl/scope_decimator.sv
`default_nettype none
// ============================================================================
// Module      : scope_decimator
// Description : Decimating / averaging stage behind the scope filter. Emits
//               one sample per cfg_dec+1 accepted input samples: either the
//               saturated, arithmetically shifted group sum (cfg_avg=1) or
//               the last sample of the group (cfg_avg=0).
// Options     : SCOPE_DECIMATOR_ROUND_EN - round half up before the shift in
//               averaging mode; otherwise the shift floors toward -inf.
// Revision    : 1.0 - initial release
// ============================================================================
module scope_decimator #(
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int CW  = 17
) (
    input  wire logic          clk,
    input  wire logic          rst,
    scope_decimator_if.slave   sti,
    scope_decimator_if.master  sto,
    input  wire logic [CW-1:0] cfg_dec,
    input  wire logic          cfg_avg,
    input  wire logic [4:0]    cfg_shr,
    input  wire logic          ctl_rst
);

    // Accumulator width and a working width wide enough for the rounding
    // bias and for the saturation bounds of the output.
    localparam int AW = DWI + CW;
    localparam int XW = ((AW + 1) > (DWO + 1)) ? (AW + 1) : (DWO + 1);

    localparam logic signed [XW-1:0] c_sat_max = {{(XW-DWO+1){1'b0}}, {(DWO-1){1'b1}}};
    localparam logic signed [XW-1:0] c_sat_min = {{(XW-DWO+1){1'b1}}, {(DWO-1){1'b0}}};
    localparam logic [CW-1:0]        c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

    // State
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 sto_vld_q, sto_vld_d;
    logic [DWO-1:0]       sto_dat_q, sto_dat_d;

    // Datapath wires
    logic                 w_sti_rdy;
    logic                 w_xfi;
    logic                 w_xfo;
    logic                 w_last;
    logic signed [AW-1:0] w_din_ext;
    logic signed [AW-1:0] w_sum;
    logic signed [XW-1:0] w_sum_x;
    logic signed [XW-1:0] w_pick_x;
    logic [4:0]           w_shr;
    logic signed [XW-1:0] w_rnd;
    logic signed [XW-1:0] w_biased;
    logic signed [XW-1:0] w_shifted;
    logic signed [XW-1:0] w_sel;
    logic [DWO-1:0]       w_sat;

    // Handshake: a held, unconsumed output blocks the input; a datapath
    // clear also blocks it for that cycle.
    assign w_sti_rdy = ~ctl_rst & (~sto_vld_q | sto.rdy);
    assign w_xfi     = sti.vld & w_sti_rdy;
    assign w_xfo     = sto_vld_q & sto.rdy;

    // ">=" rather than "==" so a group closes cleanly if cfg_dec shrinks.
    assign w_last    = (cnt_q >= cfg_dec);

    assign sti.rdy   = w_sti_rdy;
    assign sto.dat   = sto_dat_q;
    assign sto.vld   = sto_vld_q;

    // Group sum including the current sample, plus sign-extended copies at
    // the working width for the averaging and pick paths.
    assign w_din_ext = {{CW{sti.dat[DWI-1]}}, sti.dat};
    assign w_sum     = acc_q + w_din_ext;
    assign w_sum_x   = {{(XW-AW){w_sum[AW-1]}}, w_sum};
    assign w_pick_x  = {{(XW-DWI){sti.dat[DWI-1]}}, sti.dat};

    // Clamp the shift amount to CW; larger settings behave like CW.
    always_comb begin
        w_shr = cfg_shr;
        if ({27'd0, cfg_shr} > 32'(CW)) begin
            w_shr = 5'(CW);
        end
    end

    // Rounding bias of half an output LSB, only when rounding is built in.
    always_comb begin
        w_rnd = '0;
`ifdef SCOPE_DECIMATOR_ROUND_EN
        if (w_shr != 5'd0) begin
            w_rnd = {{(XW-1){1'b0}}, 1'b1} << (w_shr - 5'd1);
        end
`endif
    end

    assign w_biased  = w_sum_x + w_rnd;
    assign w_shifted = w_biased >>> w_shr;
    assign w_sel     = cfg_avg ? w_shifted : w_pick_x;

    // Saturate the selected value to the output range.
    always_comb begin
        w_sat = w_sel[DWO-1:0];
        if (w_sel > c_sat_max) begin
            w_sat = c_sat_max[DWO-1:0];
        end else if (w_sel < c_sat_min) begin
            w_sat = c_sat_min[DWO-1:0];
        end
    end

    // Next-state: accumulate mid-group, emit on the last sample, drop valid
    // once the consumer takes the output unless a new one is loaded.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sto_vld_d = sto_vld_q;
        sto_dat_d = sto_dat_q;
        if (w_xfo) begin
            sto_vld_d = 1'b0;
        end
        if (w_xfi) begin
            if (w_last) begin
                cnt_d     = '0;
                acc_d     = '0;
                sto_dat_d = w_sat;
                sto_vld_d = 1'b1;
            end else begin
                cnt_d     = cnt_q + c_cnt_one;
                acc_d     = w_sum;
            end
        end
    end

    // State register; rst and the datapath clear both discard any partial
    // group and any pending output.
    always_ff @(posedge clk) begin
        if (rst || ctl_rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            sto_vld_q <= 1'b0;
            sto_dat_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sto_vld_q <= sto_vld_d;
            sto_dat_q <= sto_dat_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/scope_decimator.md
Name: scope_decimator

Overview:
- Decimating, optionally averaging stage directly downstream of scope_filter in the scope acquisition path.
- Consumes the filtered ADC sample stream and emits one sample per N = cfg_dec+1 accepted input samples.
- Its output feeds the scope trigger and acquisition buffer.
- Averaging mode outputs the shifted sum of each group; pick mode outputs the last sample of each group.

Parameters:
DWI, 14, input sample width (signed)
DWO, 14, output sample width (signed)
CW, 17, decimation counter width; the accumulator is DWI+CW bits wide

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
sti_dat  input  DWI  input sample (signed)
sti_vld  input  1  input valid
sti_rdy  output  1  input ready
sto_dat  output  DWO  output sample (signed)
sto_vld  output  1  output valid
sto_rdy  input  1  output ready
cfg_dec  input  CW  decimation factor minus 1 (unsigned)
cfg_avg  input  1  1 = averaging, 0 = pick
cfg_shr  input  5  arithmetic right shift applied to the sum, valid range 0..CW
ctl_rst  input  1  synchronous clear of the datapath, active-high

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, acc=0, sto_vld=0, sto_dat=0. sti_rdy=1 in the cycle after reset.
- Input transfer (xfi): sti_vld & sti_rdy. Output transfer (xfo): sto_vld & sto_rdy.
- Ready rule: sti_rdy = ~sto_vld | sto_rdy (combinational). An input is never accepted while an unconsumed output is held.
- Output hold: sto_dat and sto_vld stay stable until xfo.
- On xfi with cnt < cfg_dec:
  - cnt <= cnt+1
  - acc <= acc + sext(sti_dat)
- On xfi with cnt >= cfg_dec (last sample of the group; ">=" handles cfg_dec lowered mid-group):
  - cnt <= 0, acc <= 0
  - sum = acc + sext(sti_dat), full DWI+CW width, never overflows for cfg_dec < 2^CW
  - cfg_avg=1: sto_dat <= sat_DWO(sum >>> cfg_shr)
  - cfg_avg=0: sto_dat <= sti_dat, sign-extended or saturated to DWO
  - sto_vld <= 1
- Saturation: clamp to [-2^(DWO-1), 2^(DWO-1)-1].
- cfg_shr > CW is treated as CW.
- Latency: registered output appears the cycle after the last sample of the group is accepted.
- On xfo without a simultaneous emit: sto_vld <= 0.
- Simultaneous xfo and emit in the same cycle: the new sample is loaded and sto_vld stays 1 (full throughput at cfg_dec=0).
- cfg_dec=0: every sample is emitted. With cfg_avg=1, cfg_shr=0 the output is identical to the input, 1 cycle latency.
- Configuration inputs are used live; software changes them only while ctl_rst=1.
- ctl_rst=1: same effect as rst on cnt, acc, sto_vld and sto_dat; no input is accepted that cycle (sti_rdy=0). rst has priority over everything.
- Reset mid-group: the partial sum is discarded and the next accepted sample starts a new group.
- Stalled input (sti_vld=0) mid-group: cnt and acc hold; no timeout.

Optional Feature:
Macro: SCOPE_DECIMATOR_ROUND_EN
- Defined: in averaging mode, when cfg_shr>0, 2^(cfg_shr-1) is added to sum before the shift (round half up), then saturation is applied.
- Undefined: plain arithmetic shift (floor toward -infinity).
- Pick mode is unaffected either way.

Test Plan:
1. cfg_dec=0, cfg_avg=1, cfg_shr=0, sto_rdy=1; stream -8..7 back to back -> outputs -8..7, each 1 cycle after input, sti_rdy constantly 1.
2. cfg_dec=3, cfg_avg=1, cfg_shr=2; inputs 1..8 -> outputs 2 (10>>2) and 6 (26>>2). Inputs -5,0,0,0 with cfg_shr=1 -> -3, or -2 with SCOPE_DECIMATOR_ROUND_EN.
3. cfg_dec=3, cfg_avg=0; inputs 1..12 -> outputs 4, 8, 12.
4. DWI=DWO=14, cfg_dec=3, cfg_avg=1, cfg_shr=0:
   - four samples 8191 -> output 8191 (sum 32764 saturated)
   - four samples -8192 -> output -8192
5. cfg_dec=0; hold sto_rdy=0 for 5 cycles after the first output -> sto_vld=1, sto_dat stable, sti_rdy=0. Release -> remaining samples emitted in order, none lost or duplicated.
6. cfg_dec=3, cfg_avg=1, cfg_shr=2; accept 100,100, pulse ctl_rst, then 4,4,4,4 -> single output 4, no output from the aborted group. Repeat the sequence with rst in place of ctl_rst -> same result, with all outputs at reset values the cycle after the rst edge.
